// File: rtl/ascon_pkg.sv
// ascon_pkg
//   Shared definitions for the Ascon permutation scheduler and anything that
//   models it: state geometry, round counts, FSM encoding, and the helpers
//   that build round constants and 64-bit rotations.
package ascon_pkg;

    localparam int STATE_W    = 320;
    localparam int MAX_ROUNDS = 12;
    localparam int PA_ROUNDS  = 12;
    localparam int PB_ROUNDS  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    // Round constant for schedule index idx: upper nibble is the complement
    // of the lower one (idx 0 -> 0xF0, idx 11 -> 0x4B).
    function automatic logic [7:0] round_const(input logic [3:0] idx);
        return {~idx, idx};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// ascon_round
//   One Ascon permutation round, purely combinational.
//   Ports:
//     state_in   in  320  x0..x4, x0 in bits [319:256]
//     rc         in  8    round constant, XORed into the low byte of x2
//     state_out  out 320  state after constant, S-box and linear layer
module ascon_round
    import ascon_pkg::*;
(
    input  logic [319:0] state_in,
    input  logic [7:0]   rc,
    output logic [319:0] state_out
);

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] c0, c1, c2, c3, c4;

    assign x0 = state_in[319:256];
    assign x1 = state_in[255:192];
    assign x2 = state_in[191:128] ^ {56'h0, rc};
    assign x3 = state_in[127:64];
    assign x4 = state_in[63:0];

    // Bitsliced 5-bit S-box: input mixing, chi-like core, output mixing.
    assign a0 = x0 ^ x4;
    assign a1 = x1;
    assign a2 = x2 ^ x1;
    assign a3 = x3;
    assign a4 = x4 ^ x3;

    assign b0 = a0 ^ (~a1 & a2);
    assign b1 = a1 ^ (~a2 & a3);
    assign b2 = a2 ^ (~a3 & a4);
    assign b3 = a3 ^ (~a4 & a0);
    assign b4 = a4 ^ (~a0 & a1);

    assign c0 = b0 ^ b4;
    assign c1 = b1 ^ b0;
    assign c2 = ~b2;
    assign c3 = b3 ^ b2;
    assign c4 = b4;

    // Linear diffusion layer, one rotation pair per word.
    assign state_out[319:256] = c0 ^ ror64(c0, 19) ^ ror64(c0, 28);
    assign state_out[255:192] = c1 ^ ror64(c1, 61) ^ ror64(c1, 39);
    assign state_out[191:128] = c2 ^ ror64(c2, 1)  ^ ror64(c2, 6);
    assign state_out[127:64]  = c3 ^ ror64(c3, 10) ^ ror64(c3, 17);
    assign state_out[63:0]    = c4 ^ ror64(c4, 7)  ^ ror64(c4, 41);

endmodule

// File: rtl/ascon_perm_scheduler.sv
// ascon_perm_scheduler
//   Shares one iterative Ascon round between NUM_REQ requesters. A
//   round-robin arbiter picks a requester in IDLE, its state and round count
//   are latched, one round runs per cycle, and the result is presented on
//   state_out together with a one-cycle done pulse to the owner.
//   Ports:
//     clk         in   1                 rising-edge clock
//     rst         in   1                 asynchronous active-low reset
//     req         in   NUM_REQ           level request per requester
//     req_rounds  in   4*NUM_REQ         round count per requester
//     req_state   in   STATE_W*NUM_REQ   input state per requester
//     grant       out  NUM_REQ           one-hot owner, accept through done
//     done        out  NUM_REQ           one-cycle completion pulse to owner
//     state_out   out  STATE_W           result, held until the next result
//     busy        out  1                 a job is running or completing
module ascon_perm_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int STATE_W    = 320,
    parameter int MAX_ROUNDS = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [4*NUM_REQ-1:0]       req_rounds,
    input  logic [STATE_W*NUM_REQ-1:0] req_state,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [STATE_W-1:0]         state_out,
    output logic                       busy
);

    import ascon_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_t       fsm_reg, fsm_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic [IDX_W-1:0]   rr_reg, rr_next;
    logic [3:0]         rc_idx_reg, rc_idx_next;
    logic [STATE_W-1:0] state_reg, state_next;
    logic [STATE_W-1:0] state_out_reg, state_out_next;

    logic [STATE_W-1:0] req_state_arr [NUM_REQ];
    logic [3:0]         req_rounds_arr [NUM_REQ];
    logic [IDX_W-1:0]   sel_idx;
    logic [3:0]         sel_rounds;
    logic [3:0]         eff_rounds;
    logic [STATE_W-1:0] round_out;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_state_arr[gi]  = req_state[gi*STATE_W +: STATE_W];
            assign req_rounds_arr[gi] = req_rounds[gi*4 +: 4];
            assign grant[gi] = (fsm_reg != ST_IDLE) && (owner_reg == IDX_W'(gi));
            assign done[gi]  = (fsm_reg == ST_DONE) && (owner_reg == IDX_W'(gi));
        end
    endgenerate

    assign busy      = (fsm_reg != ST_IDLE);
    assign state_out = state_out_reg;

    // Round-robin pick: first set request at or after rr_reg, wrapping.
    always_comb begin
        int   cand;
        logic found;
        sel_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_reg) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found   = 1'b1;
                sel_idx = IDX_W'(cand);
            end
        end
    end

    // Zero or out-of-range counts fall back to the full p^a schedule.
    assign sel_rounds = req_rounds_arr[sel_idx];
    assign eff_rounds = (sel_rounds == 4'd0 || sel_rounds > 4'(MAX_ROUNDS))
                        ? 4'(MAX_ROUNDS) : sel_rounds;

    ascon_round u_round (
        .state_in  (state_reg),
        .rc        (round_const(rc_idx_reg)),
        .state_out (round_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_reg       <= ST_IDLE;
            owner_reg     <= '0;
            rr_reg        <= '0;
            rc_idx_reg    <= '0;
            state_reg     <= '0;
            state_out_reg <= '0;
        end else begin
            fsm_reg       <= fsm_next;
            owner_reg     <= owner_next;
            rr_reg        <= rr_next;
            rc_idx_reg    <= rc_idx_next;
            state_reg     <= state_next;
            state_out_reg <= state_out_next;
        end
    end

    always_comb begin
        fsm_next       = fsm_reg;
        owner_next     = owner_reg;
        rr_next        = rr_reg;
        rc_idx_next    = rc_idx_reg;
        state_next     = state_reg;
        state_out_next = state_out_reg;
        unique case (fsm_reg)
            ST_IDLE: begin
                if (|req) begin
                    owner_next  = sel_idx;
                    state_next  = req_state_arr[sel_idx];
                    // Short schedules start late so they always end on idx MAX_ROUNDS-1.
                    rc_idx_next = 4'(MAX_ROUNDS) - eff_rounds;
                    fsm_next    = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next  = round_out;
                rc_idx_next = rc_idx_reg + 4'd1;
                if (rc_idx_reg == 4'(MAX_ROUNDS - 1)) begin
                    // Publish the final round directly so state_out is valid with done.
                    state_out_next = round_out;
                    fsm_next       = ST_DONE;
                end
            end
            ST_DONE: begin
                fsm_next = ST_IDLE;
                rr_next  = (owner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
            end
            default: begin
                fsm_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ascon_perm_scheduler.sv
module tb_ascon_perm_scheduler;

    localparam int N  = 2;
    localparam int SW = 320;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [4*N-1:0]  req_rounds = '0;
    logic [SW*N-1:0] req_state = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic [SW-1:0]   state_out;
    logic            busy;

    int errors = 0;
    int checks = 0;
    bit [4:0] sbox [32];

    ascon_perm_scheduler #(.NUM_REQ(N), .STATE_W(SW), .MAX_ROUNDS(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_rounds (req_rounds),
        .req_state  (req_state),
        .grant      (grant),
        .done       (done),
        .state_out  (state_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rot(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic int norm_rounds(input int r);
        return (r == 0 || r > 12) ? 12 : r;
    endfunction

    // Reference permutation: table-driven S-box applied column by column.
    function automatic logic [SW-1:0] model_perm(input logic [SW-1:0] s, input int rounds);
        logic [63:0] x [5];
        logic [SW-1:0] res;
        int r;
        bit [4:0] v, o;
        r = norm_rounds(rounds);
        for (int i = 0; i < 5; i++) x[i] = s[SW-1-64*i -: 64];
        for (int k = 12 - r; k < 12; k++) begin
            x[2] = x[2] ^ 64'((15 - k) * 16 + k);
            for (int j = 0; j < 64; j++) begin
                v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
                o = sbox[v];
                x[0][j] = o[4]; x[1][j] = o[3]; x[2][j] = o[2];
                x[3][j] = o[1]; x[4][j] = o[0];
            end
            x[0] = x[0] ^ rot(x[0], 19) ^ rot(x[0], 28);
            x[1] = x[1] ^ rot(x[1], 61) ^ rot(x[1], 39);
            x[2] = x[2] ^ rot(x[2], 1)  ^ rot(x[2], 6);
            x[3] = x[3] ^ rot(x[3], 10) ^ rot(x[3], 17);
            x[4] = x[4] ^ rot(x[4], 7)  ^ rot(x[4], 41);
        end
        res = {x[0], x[1], x[2], x[3], x[4]};
        return res;
    endfunction

    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] s;
        for (int i = 0; i < SW / 32; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic start_req(input int idx, input logic [3:0] r, input logic [SW-1:0] s);
        req_rounds[4*idx +: 4] = r;
        req_state[SW*idx +: SW] = s;
        req[idx] = 1'b1;
    endtask

    // Accept must land on the very next edge when the scheduler is idle.
    task automatic wait_accept(input int idx, input string tag);
        int n = 0;
        while (grant[idx] !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk32({tag, " accept_edges"}, 32'(n), 32'd1);
        chk32({tag, " grant"}, 32'(grant), 32'(1 << idx));
        $display("%s: req%0d granted after %0d edge(s)", tag, idx, n);
    endtask

    // Called just after the accept edge; cycle 1 is the first cycle after it.
    task automatic wait_done(input int idx, input int rounds, input logic [SW-1:0] s,
                             input string tag, input int drop_cycle);
        int cyc = 1;
        int er  = norm_rounds(rounds);
        while (done === '0 && cyc < 40) begin
            if (cyc == drop_cycle) req[idx] = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk32({tag, " latency"}, 32'(cyc), 32'(er + 1));
        chk32({tag, " done"}, 32'(done), 32'(1 << idx));
        chk32({tag, " grant_at_done"}, 32'(grant), 32'(1 << idx));
        chk({tag, " state_out"}, state_out, model_perm(s, rounds));
        $display("%s: req%0d r=%0d done in cycle %0d state_out=%0h", tag, idx, rounds, cyc, state_out);
        req[idx] = 1'b0;
        @(posedge clk); #1;
        chk32({tag, " done_pulse_end"}, 32'(done), 32'd0);
        chk32({tag, " idle_grant"}, 32'(grant), 32'd0);
        chk32({tag, " idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [SW-1:0] s0, s1;
        logic [127:0]  key, nonce;
        int            done_seen;
        int            idx, r;

        sbox = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                 5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                 5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                 5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk32("rst grant", 32'(grant), 32'd0);
        chk32("rst done", 32'(done), 32'd0);
        chk32("rst busy", 32'(busy), 32'd0);
        chk("rst state_out", state_out, '0);
        rst = 1'b1;
        @(posedge clk); #1;

        // p^12 of the all-zero state on requester 0
        start_req(0, 4'd12, '0);
        wait_accept(0, "zero_p12");
        wait_done(0, 12, '0, "zero_p12", 0);

        // Reset mid-run: everything clears without a clock edge, no done later
        s0 = rand_state();
        start_req(0, 4'd12, s0);
        wait_accept(0, "midrun_rst");
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk32("midrun_rst grant", 32'(grant), 32'd0);
        chk32("midrun_rst busy", 32'(busy), 32'd0);
        chk("midrun_rst state_out", state_out, '0);
        req = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done !== '0 || busy !== 1'b0) done_seen++;
        end
        chk32("midrun_rst no_done", 32'(done_seen), 32'd0);
        $display("midrun_rst: outputs cleared, %0d spurious activity cycles", done_seen);

        // p^6 on requester 1 with an Ascon-128 style initial state
        key   = {$urandom, $urandom, $urandom, $urandom};
        nonce = {$urandom, $urandom, $urandom, $urandom};
        s1 = {64'h80400c0600000000, key, nonce};
        start_req(1, 4'd6, s1);
        wait_accept(1, "iv_p6");
        wait_done(1, 6, s1, "iv_p6", 0);

        // Simultaneous requests with rr pointer at 0
        s0 = rand_state();
        s1 = rand_state();
        start_req(0, 4'd5, s0);
        start_req(1, 4'd9, s1);
        wait_accept(0, "both_first");
        wait_done(0, 5, s0, "both_first", 0);
        wait_accept(1, "both_second");
        wait_done(1, 9, s1, "both_second", 0);

        // Out-of-range round counts behave as 12
        s0 = rand_state();
        start_req(0, 4'd0, s0);
        wait_accept(0, "r0");
        wait_done(0, 0, s0, "r0", 0);
        s0 = rand_state();
        start_req(0, 4'd13, s0);
        wait_accept(0, "r13");
        wait_done(0, 13, s0, "r13", 0);

        // Owner drops req in cycle 3 of RUN; pending req1 follows
        s0 = rand_state();
        s1 = rand_state();
        start_req(0, 4'd8, s0);
        wait_accept(0, "drop");
        start_req(1, 4'd4, s1);
        wait_done(0, 8, s0, "drop", 3);
        wait_accept(1, "drop_next");
        wait_done(1, 4, s1, "drop_next", 0);

        // Randomized single-requester jobs
        for (int t = 0; t < 8; t++) begin
            idx = $urandom_range(0, N - 1);
            r   = $urandom_range(0, 15);
            s0  = rand_state();
            start_req(idx, 4'(r), s0);
            wait_accept(idx, "rand");
            wait_done(idx, r, s0, "rand", 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
